matrix_mult_seq: RTL and testbench
==================================

Name: matrix_mult_seq

Overview:
- Parametrised, clocked successor to the combinational 4x4 matrix multiplier.
- Accepts matrix A, then matrix B, as two full-bus beats on a valid/ready input, and computes C = A x B with a single time-shared multiply-accumulate unit.
- Returns C on a valid/ready output, with selectable saturate or wrap narrowing and an overflow flag.
- Sits between the bus-side loader and the result writer in the math engine.

Parameters:
- DIM, 4, matrix dimension (square DIM x DIM); legal values 2..8.
- DW, 16, element width in bits, unsigned.
- SATURATE, 1, result narrowing mode: 1 clamps to 2^DW-1; 0 keeps the low DW bits (wrap).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous abort; discards any loaded operands and results
- in_valid  in  1  in_data holds a matrix beat
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  DIM*DIM*DW  matrix; element (r,c) at bits [(r*DIM+c)*DW +: DW]
- out_valid  out  1  out_data holds C
- out_ready  in  1  consumer accepts C
- out_data  out  DIM*DIM*DW  C, packed the same way as in_data
- out_ovf  out  1  at least one element of C exceeded 2^DW-1 before narrowing
- busy  out  1  high in COMPUTE

Behaviour:
- One clock. Reset is synchronous and active-low. All control, counters and outputs update only on the rising edge of clk.
- Reset (rst_n=0 at an edge), including mid-operation:
  - state goes to LOAD_A;
  - in_ready=0 during reset cycles, then 1;
  - out_valid=0, out_data=0, out_ovf=0, busy=0;
  - counters and accumulator cleared;
  - operand storage need not be cleared.
- States are LOAD_A, LOAD_B, COMPUTE and DONE.
- LOAD_A:
  - in_ready=1.
  - On in_valid&&in_ready, store A and go to LOAD_B.
- LOAD_B:
  - in_ready=1.
  - On a handshake, store B, clear the accumulator and the r/c/k counters, clear the internal overflow flag, and go to COMPUTE.
- COMPUTE:
  - in_ready=0, busy=1.
  - Each cycle: acc <= acc + A[r][k]*B[k][c]. The first term of each element uses acc=0, not the stale sum.
  - k increments fastest, then c, then r.
  - When k==DIM-1, the full sum is narrowed and written to C[r][c], k resets and the accumulator restarts.
  - After the MAC with r=c=k=DIM-1, go to DONE.
  - Exactly DIM^3 cycles. out_valid rises DIM^3 edges after the edge that accepted B (64 edges at DIM=4).
- Arithmetic:
  - Product width is 2*DW.
  - Accumulator width is 2*DW+clog2(DIM); it never overflows internally.
  - Narrowing: if the sum exceeds 2^DW-1, set the overflow flag, then clamp (SATURATE=1) or truncate (SATURATE=0).
- DONE:
  - out_valid=1. out_data and out_ovf are held stable while out_ready=0.
  - in_ready=0; a new A is not accepted until C is consumed.
  - On out_valid&&out_ready, go to LOAD_A, deassert out_valid, and leave out_data holding its last value.
- flush:
  - When high at an edge in any state, go to LOAD_A, out_valid=0, out_ovf=0.
  - flush has priority over every handshake in the same cycle.
  - rst_n has priority over flush.
- in_valid is ignored outside LOAD_A/LOAD_B. out_ready is ignored outside DONE.
- Back-to-back: A may be presented in the cycle after C is consumed, so in_ready rises one edge after the output handshake.

Test Plan:
- A = identity, B[r][c]=r*4+c+1 (DIM=4, DW=16, SATURATE=1) -> out_data == B; out_ovf=0; out_valid exactly 64 edges after the B handshake.
- A all 0x0002, B all 0x0003 -> every C element 0x0018. Second pair A[r][k]=r+k, B[k][c]=k*c -> C matches the software reference model element-wise.
- A, B all 0xFFFF:
  - SATURATE=1 -> every element 0xFFFF, out_ovf=1.
  - SATURATE=0 -> every element 0x0004 (low 16 bits of 0x3FFF80004), out_ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 -> out_data stable, in_ready=0, no beat accepted. Raise out_ready -> one handshake, then in_ready=1 on the next edge.
- flush at cycle 30 of COMPUTE, then load a new A/B pair -> no out_valid for the aborted pair; the new result is correct with out_ovf from the new pair only.
- rst_n low for one cycle in LOAD_B and again in DONE -> after each: in_ready=1, out_valid=0, out_ovf=0, and the next A beat loads as A (not B).

Source files
------------

// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: sequential DIM x DIM unsigned matrix multiplier.
// Accepts A then B as full-bus beats, computes C = A x B with one shared
// multiply-accumulate unit (DIM^3 cycles), then presents C on a
// valid/ready output with saturating or wrapping narrowing.
module matrix_mult_seq #(
  parameter int DIM      = 4,
  parameter int DW       = 16,
  parameter int SATURATE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIM*DIM*DW-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIM*DIM*DW-1:0] out_data,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int BW = DIM * DIM * DW;
  localparam int CW = $clog2(DIM);
  localparam int PW = 2 * DW;
  localparam int AW = 2 * DW + $clog2(DIM);
  localparam logic [CW-1:0] LAST = CW'(DIM - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DONE} state_t;

  state_t          r_state;
  logic [DW-1:0]   r_aMat [DIM][DIM];
  logic [DW-1:0]   r_bMat [DIM][DIM];
  logic [DW-1:0]   r_cMat [DIM][DIM];
  logic [CW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [CW-1:0]   r_k;
  logic [AW-1:0]   r_acc;
  logic            r_ovfAcc;
  logic            r_inReady;
  logic            r_outValid;
  logic            r_outOvf;
  logic            r_busy;
  logic [BW-1:0]   r_outData;

  logic [PW-1:0]   w_prod;
  logic [AW-1:0]   w_sum;
  logic            w_over;
  logic [DW-1:0]   w_narrow;
  logic            w_inFire;
  logic            w_outFire;

  // The first term of each element starts from zero instead of the stale sum,
  // so the accumulator never needs a separate clear cycle between elements.
  assign w_prod    = PW'(r_aMat[r_row][r_k]) * PW'(r_bMat[r_k][r_col]);
  assign w_sum     = ((r_k == '0) ? '0 : r_acc) + AW'(w_prod);
  assign w_over    = (w_sum[AW-1:DW] != '0);
  assign w_narrow  = (w_over && (SATURATE != 0)) ? {DW{1'b1}} : w_sum[DW-1:0];
  assign w_inFire  = in_valid && r_inReady;
  assign w_outFire = r_outValid && out_ready;

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_ovf   = r_outOvf;
  assign busy      = r_busy;

  // Control FSM, operand capture, MAC sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= LOAD_A;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outOvf   <= 1'b0;
      r_busy     <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_ovfAcc   <= 1'b0;
    end else if (flush) begin
      r_state    <= LOAD_A;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_outOvf   <= 1'b0;
      r_busy     <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_ovfAcc   <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A: begin
          r_inReady <= 1'b1;
          if (w_inFire) begin
            for (int i = 0; i < DIM; i++)
              for (int j = 0; j < DIM; j++)
                r_aMat[i][j] <= in_data[(i*DIM+j)*DW +: DW];
            r_state <= LOAD_B;
          end
        end
        LOAD_B: begin
          r_inReady <= 1'b1;
          if (w_inFire) begin
            for (int i = 0; i < DIM; i++)
              for (int j = 0; j < DIM; j++)
                r_bMat[i][j] <= in_data[(i*DIM+j)*DW +: DW];
            r_row     <= '0;
            r_col     <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_ovfAcc  <= 1'b0;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= COMPUTE;
          end
        end
        COMPUTE: begin
          r_acc <= w_sum;
          if (r_k == LAST) begin
            r_cMat[r_row][r_col] <= w_narrow;
            r_ovfAcc             <= r_ovfAcc | w_over;
            r_k                  <= '0;
            if (r_col == LAST) begin
              r_col <= '0;
              if (r_row == LAST) begin
                r_row      <= '0;
                r_busy     <= 1'b0;
                r_outValid <= 1'b1;
                r_outOvf   <= r_ovfAcc | w_over;
                r_state    <= DONE;
                for (int i = 0; i < DIM; i++)
                  for (int j = 0; j < DIM; j++)
                    r_outData[(i*DIM+j)*DW +: DW] <=
                      ((i == DIM - 1) && (j == DIM - 1)) ? w_narrow : r_cMat[i][j];
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          if (w_outFire) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= LOAD_A;
          end
        end
        default: r_state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// tb_matrix_mult_seq: scoreboard bench for matrix_mult_seq. Two instances
// (saturating and wrapping) share all inputs; expected results come from a
// software model pushed at B acceptance and popped at the output handshake.
module tb_matrix_mult_seq;

  localparam int DIM = 4;
  localparam int DW  = 16;
  localparam int BW  = DIM * DIM * DW;

  typedef struct {
    logic [BW-1:0] dataSat;
    logic [BW-1:0] dataWrap;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [BW-1:0] in_data = '0;

  logic          inReadyS, outValidS, ovfS, busyS;
  logic [BW-1:0] outDataS;
  logic          inReadyW, outValidW, ovfW, busyW;
  logic [BW-1:0] outDataW;

  exp_t sbQueue[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycleCount = 0;
  int   bAcceptCycle = 0;

  matrix_mult_seq #(.DIM(DIM), .DW(DW), .SATURATE(1)) dutSat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(inReadyS), .in_data(in_data),
    .out_valid(outValidS), .out_ready(out_ready), .out_data(outDataS),
    .out_ovf(ovfS), .busy(busyS)
  );

  matrix_mult_seq #(.DIM(DIM), .DW(DW), .SATURATE(0)) dutWrap (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(inReadyW), .in_data(in_data),
    .out_valid(outValidW), .out_ready(out_ready), .out_data(outDataW),
    .out_ovf(ovfW), .busy(busyW)
  );

  // Free-running clock and an edge counter used for latency measurement.
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exhausted, required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] getEl(input logic [BW-1:0] m, input int r, input int c);
    return m[(r*DIM+c)*DW +: DW];
  endfunction

  function automatic logic [BW-1:0] fillAll(input logic [DW-1:0] v);
    logic [BW-1:0] m;
    for (int i = 0; i < DIM * DIM; i++) m[i*DW +: DW] = v;
    return m;
  endfunction

  // Reference model: exact 64-bit sums, then both narrowing flavours.
  function automatic exp_t model(input logic [BW-1:0] a, input logic [BW-1:0] b);
    exp_t   e;
    longint sum;
    e.dataSat  = '0;
    e.dataWrap = '0;
    e.ovf      = 1'b0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        sum = 0;
        for (int k = 0; k < DIM; k++)
          sum += longint'(getEl(a, r, k)) * longint'(getEl(b, k, c));
        e.dataWrap[(r*DIM+c)*DW +: DW] = sum[DW-1:0];
        if (sum > 65535) begin
          e.ovf = 1'b1;
          e.dataSat[(r*DIM+c)*DW +: DW] = 16'hFFFF;
        end else begin
          e.dataSat[(r*DIM+c)*DW +: DW] = sum[DW-1:0];
        end
      end
    end
    return e;
  endfunction

  task automatic sendBeat(input logic [BW-1:0] d);
    int waitCnt = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!inReadyS && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    vectors++;
    if (inReadyS !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL beat_accept: in_ready=%b required 1", inReadyS);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic loadPair(input logic [BW-1:0] a, input logic [BW-1:0] b, input bit push);
    sendBeat(a);
    sendBeat(b);
    bAcceptCycle = cycleCount;
    if (push) sbQueue.push_back(model(a, b));
  endtask

  task automatic awaitValid(output int latency);
    int waitCnt = 0;
    while (!outValidS && waitCnt < 200) begin
      tick();
      waitCnt++;
    end
    latency = cycleCount - bAcceptCycle;
    vectors++;
    if (outValidS !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL out_valid_timeout: out_valid=%b required 1", outValidS);
    end
  endtask

  task automatic consume();
    exp_t e;
    vectors++;
    if (sbQueue.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: size=0 required >0");
    end else begin
      e = sbQueue.pop_front();
      vectors += 4;
      if (outDataS !== e.dataSat) begin
        miscompares++;
        $display("[TB] FAIL sat_data: got %h want %h", outDataS, e.dataSat);
      end
      if (ovfS !== e.ovf) begin
        miscompares++;
        $display("[TB] FAIL sat_ovf: got %b want %b", ovfS, e.ovf);
      end
      if (outDataW !== e.dataWrap) begin
        miscompares++;
        $display("[TB] FAIL wrap_data: got %h want %h", outDataW, e.dataWrap);
      end
      if (ovfW !== e.ovf) begin
        miscompares++;
        $display("[TB] FAIL wrap_ovf: got %b want %b", ovfW, e.ovf);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    vectors += 2;
    if (outValidS !== 1'b0 || outValidW !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL post_handshake_valid: got %b/%b want 0", outValidS, outValidW);
    end
    if (inReadyS !== 1'b1 || inReadyW !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL post_handshake_ready: got %b/%b want 1", inReadyS, inReadyW);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vectors += 5;
    if (inReadyS !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b want 0", inReadyS);
    end
    if (outValidS !== 1'b0 || outValidW !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid: got %b/%b want 0", outValidS, outValidW);
    end
    if (outDataS !== '0 || outDataW !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_data: got %h want 0", outDataS);
    end
    if (ovfS !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ovf: got %b want 0", ovfS);
    end
    if (busyS !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy: got %b want 0", busyS);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (inReadyS !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_release_ready: got %b want 1", inReadyS);
    end
  endtask

  task automatic test_identity();
    logic [BW-1:0] a, b;
    int lat;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        a[(r*DIM+c)*DW +: DW] = (r == c) ? 16'd1 : 16'd0;
        b[(r*DIM+c)*DW +: DW] = 16'(r * 4 + c + 1);
      end
    loadPair(a, b, 1'b1);
    vectors += 2;
    if (busyS !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL compute_busy: got %b want 1", busyS);
    end
    if (inReadyS !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL compute_in_ready: got %b want 0", inReadyS);
    end
    awaitValid(lat);
    vectors += 2;
    if (lat != 64) begin
      miscompares++;
      $display("[TB] FAIL identity_latency: got %0d want 64", lat);
    end
    if (outDataS !== b) begin
      miscompares++;
      $display("[TB] FAIL identity_equals_b: got %h want %h", outDataS, b);
    end
    consume();
  endtask

  task automatic test_patterns();
    logic [BW-1:0] a, b;
    int lat;
    loadPair(fillAll(16'h0002), fillAll(16'h0003), 1'b1);
    awaitValid(lat);
    vectors++;
    if (outDataS !== fillAll(16'h0018)) begin
      miscompares++;
      $display("[TB] FAIL const_0018: got %h want all 0018", outDataS);
    end
    consume();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        a[(r*DIM+c)*DW +: DW] = 16'(r + c);
        b[(r*DIM+c)*DW +: DW] = 16'(r * c);
      end
    loadPair(a, b, 1'b1);
    awaitValid(lat);
    consume();
  endtask

  task automatic test_overflow();
    int lat;
    loadPair(fillAll(16'hFFFF), fillAll(16'hFFFF), 1'b1);
    awaitValid(lat);
    vectors += 2;
    if (outDataS !== fillAll(16'hFFFF) || ovfS !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sat_clamp: got %h ovf %b want all FFFF ovf 1", outDataS, ovfS);
    end
    if (outDataW !== fillAll(16'h0004) || ovfW !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wrap_trunc: got %h ovf %b want all 0004 ovf 1", outDataW, ovfW);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] held;
    logic [BW-1:0] a, b;
    int lat;
    for (int i = 0; i < DIM * DIM; i++) begin
      a[i*DW +: DW] = 16'(i + 3);
      b[i*DW +: DW] = 16'(2 * i + 1);
    end
    loadPair(a, b, 1'b1);
    awaitValid(lat);
    held     = outDataS;
    in_valid = 1'b1;
    in_data  = fillAll(16'h5A5A);
    for (int n = 0; n < 10; n++) begin
      tick();
      vectors += 3;
      if (outDataS !== held) begin
        miscompares++;
        $display("[TB] FAIL bp_data_stable: cycle %0d got %h want %h", n, outDataS, held);
      end
      if (inReadyS !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_in_ready: cycle %0d got %b want 0", n, inReadyS);
      end
      if (outValidS !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL bp_out_valid: cycle %0d got %b want 1", n, outValidS);
      end
    end
    consume();
    loadPair(b, a, 1'b1);
    awaitValid(lat);
    consume();
  endtask

  task automatic test_flush();
    logic [BW-1:0] a, b;
    int lat;
    bit sawValid = 1'b0;
    loadPair(fillAll(16'hFFFF), fillAll(16'hFFFF), 1'b0);
    repeat (29) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors += 3;
    if (outValidS !== 1'b0 || ovfS !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_outputs: valid %b ovf %b want 0 0", outValidS, ovfS);
    end
    if (busyS !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_busy: got %b want 0", busyS);
    end
    if (inReadyS !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_in_ready: got %b want 1", inReadyS);
    end
    for (int n = 0; n < 80; n++) begin
      tick();
      if (outValidS) sawValid = 1'b1;
    end
    vectors++;
    if (sawValid) begin
      miscompares++;
      $display("[TB] FAIL flush_no_result: saw out_valid=1 want 0");
    end
    for (int i = 0; i < DIM * DIM; i++) begin
      a[i*DW +: DW] = 16'(i);
      b[i*DW +: DW] = 16'(DIM * DIM - i);
    end
    loadPair(a, b, 1'b1);
    awaitValid(lat);
    vectors++;
    if (lat != 64) begin
      miscompares++;
      $display("[TB] FAIL flush_new_latency: got %0d want 64", lat);
    end
    consume();
  endtask

  task automatic test_reset_midop();
    logic [BW-1:0] a, b;
    int lat;
    exp_t dropped;
    for (int i = 0; i < DIM * DIM; i++) begin
      a[i*DW +: DW] = 16'(i * 7 + 1);
      b[i*DW +: DW] = 16'(i + 5);
    end
    sendBeat(fillAll(16'h1234));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors += 2;
    if (outValidS !== 1'b0 || ovfS !== 1'b0 || inReadyS !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstb_outputs: valid %b ovf %b ready %b want 0 0 0", outValidS, ovfS, inReadyS);
    end
    tick();
    if (inReadyS !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstb_ready_after: got %b want 1", inReadyS);
    end
    loadPair(a, b, 1'b1);
    awaitValid(lat);
    consume();
    loadPair(fillAll(16'hFFFF), fillAll(16'hFFFF), 1'b1);
    awaitValid(lat);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if (sbQueue.size() > 0) dropped = sbQueue.pop_front();
    vectors += 2;
    if (outValidS !== 1'b0 || ovfS !== 1'b0 || outDataS !== '0) begin
      miscompares++;
      $display("[TB] FAIL rstd_outputs: valid %b ovf %b data %h want 0", outValidS, ovfS, outDataS);
    end
    tick();
    if (inReadyS !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstd_ready_after: got %b want 1", inReadyS);
    end
    loadPair(b, a, 1'b1);
    awaitValid(lat);
    consume();
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_identity();
    test_patterns();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
